pwm_capture: RTL and testbench

- Decodes an incoming PWM waveform, the receive-side counterpart of the counter-compare PWM generators that drive our LED outputs.
- Synchronises one asynchronous PWM input, then measures period and high time in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a line that is stuck high or stuck low. Used for loopback checks of our own PWM outputs and for reading external PWM sources on GPIO.

---
 rtl/pwm_capture_pkg.sv | 16 +
 rtl/pwm_capture_sync_edge.sv | 40 ++++
 rtl/pwm_capture.sv | 112 +++++++++++
 tb/tb_pwm_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: default widths, FSM state
// encoding and the LED PWM generator width used for loopback pairing.
package pwm_capture_pkg;

    localparam int CNT_WIDTH_DEF   = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Counter width of the LED PWM generators (period 1024 at full scale).
    localparam int LED_PWM_WIDTH   = 10;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input plus a delayed copy,
// giving the synchronised level and a one-cycle rising-edge strobe.
module sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic [SYNC_STAGES-1:0] stage_next;
    logic                   s_d_reg;

    assign stage_next[0] = din;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
            s_d_reg   <= 1'b0;
        end else begin
            stage_reg <= stage_next;
            s_d_reg   <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign s    = stage_reg[SYNC_STAGES-1];
    assign rise = stage_reg[SYNC_STAGES-1] & ~s_d_reg;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period and high time between successive rising edges
// of a synchronised input, and flags a line that stops toggling.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 stuck_hi,
    output logic                 stuck_lo
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic s;
    logic rise;

    logic [CNT_WIDTH-1:0] cnt_period_reg, cnt_period_next;
    logic [CNT_WIDTH-1:0] cnt_high_reg,   cnt_high_next;
    logic [CNT_WIDTH-1:0] period_reg,     period_next;
    logic [CNT_WIDTH-1:0] high_time_reg,  high_time_next;
    logic                 meas_valid_reg, meas_valid_next;
    logic                 stuck_hi_reg,   stuck_hi_next;
    logic                 stuck_lo_reg,   stuck_lo_next;
    state_t               state_reg,      state_next;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwm_in),
        .s    (s),
        .rise (rise)
    );

    always_comb begin
        cnt_period_next = cnt_period_reg;
        cnt_high_next   = cnt_high_reg;
        period_next     = period_reg;
        high_time_next  = high_time_reg;
        meas_valid_next = 1'b0;
        stuck_hi_next   = stuck_hi_reg;
        stuck_lo_next   = stuck_lo_reg;
        state_next      = state_reg;

        if (rise) begin
            // The edge cycle itself counts as the first period and high cycle,
            // so at the next edge the counters hold exactly P and H.
            cnt_period_next = CNT_ONE;
            cnt_high_next   = CNT_ONE;
            stuck_hi_next   = 1'b0;
            stuck_lo_next   = 1'b0;
            state_next      = ST_RUN;
            if (state_reg == ST_RUN) begin
                period_next     = cnt_period_reg;
                high_time_next  = cnt_high_reg;
                meas_valid_next = 1'b1;
            end
        end else begin
            if (cnt_period_reg != CNT_MAX) begin
                cnt_period_next = cnt_period_reg + CNT_ONE;
            end
            if (s && (cnt_high_reg != CNT_MAX)) begin
                cnt_high_next = cnt_high_reg + CNT_ONE;
            end
            // Timeout applies in IDLE as well, so a line that never toggles
            // after reset still gets flagged.
            if (cnt_period_reg == CNT_MAX) begin
                state_next    = ST_IDLE;
                stuck_hi_next = s;
                stuck_lo_next = ~s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_period_reg <= '0;
            cnt_high_reg   <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            stuck_hi_reg   <= 1'b0;
            stuck_lo_reg   <= 1'b0;
            state_reg      <= ST_IDLE;
        end else begin
            cnt_period_reg <= cnt_period_next;
            cnt_high_reg   <= cnt_high_next;
            period_reg     <= period_next;
            high_time_reg  <= high_time_next;
            meas_valid_reg <= meas_valid_next;
            stuck_hi_reg   <= stuck_hi_next;
            stuck_lo_reg   <= stuck_lo_next;
            state_reg      <= state_next;
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = meas_valid_reg;
    assign stuck_hi   = stuck_hi_reg;
    assign stuck_lo   = stuck_lo_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance for long PWM periods and
// an 8-bit instance for timeout, minimum-period and saturation edge cases.
module tb_pwm_capture;

    localparam int WA = 16;
    localparam int WB = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_a = 1'b0;
    logic          pwm_b = 1'b0;

    logic [WA-1:0] period_a, high_a;
    logic          valid_a, shi_a, slo_a;
    logic [WB-1:0] period_b, high_b;
    logic          valid_b, shi_b, slo_b;

    pwm_capture #(.CNT_WIDTH(WA), .SYNC_STAGES(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_a),
        .period    (period_a),
        .high_time (high_a),
        .meas_valid(valid_a),
        .stuck_hi  (shi_a),
        .stuck_lo  (slo_a)
    );

    pwm_capture #(.CNT_WIDTH(WB), .SYNC_STAGES(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_b),
        .period    (period_b),
        .high_time (high_b),
        .meas_valid(valid_b),
        .stuck_hi  (shi_b),
        .stuck_lo  (slo_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int vcyc_a[$], vper_a[$], vhi_a[$];
    int vcyc_b[$], vper_b[$], vhi_b[$];
    int rise_cyc[$];
    int wide_a = 0, wide_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    // One line per completed measurement, plus width tracking of the strobe.
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            vcyc_a.push_back(cyc);
            vper_a.push_back(int'(period_a));
            vhi_a.push_back(int'(high_a));
            $display("meas A cyc=%0d period=%0d high_time=%0d", cyc, period_a, high_a);
        end
        if (valid_b === 1'b1) begin
            vcyc_b.push_back(cyc);
            vper_b.push_back(int'(period_b));
            vhi_b.push_back(int'(high_b));
            $display("meas B cyc=%0d period=%0d high_time=%0d", cyc, period_b, high_b);
        end
        if (valid_a === 1'b1 && prev_a === 1'b1) wide_a <= wide_a + 1;
        if (valid_b === 1'b1 && prev_b === 1'b1) wide_b <= wide_b + 1;
        prev_a <= valid_a;
        prev_b <= valid_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        logic cur;
        cur = sel ? pwm_b : pwm_a;
        if (v && !cur) rise_cyc.push_back(cyc);
        if (sel) pwm_b = v;
        else     pwm_a = v;
    endtask

    task automatic wave(input bit sel, input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < per; i++) begin
                drive(sel, i < hi);
                tick();
            end
        end
    endtask

    task automatic pulse_rise(input bit sel);
        drive(sel, 1'b1);
        tick();
        drive(sel, 1'b0);
        tick();
    endtask

    task automatic clear_q();
        vcyc_a.delete(); vper_a.delete(); vhi_a.delete();
        vcyc_b.delete(); vper_b.delete(); vhi_b.delete();
        rise_cyc.delete();
    endtask

    // Reset asserted and released away from the clock edge; optionally probes
    // that the outputs clear before any further clock edge.
    task automatic do_reset(input bit probe);
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        if (probe) begin
            check("rst_async_period_a", period_a, 0);
            check("rst_async_high_a", high_a, 0);
            check("rst_async_valid_a", valid_a, 0);
            check("rst_async_stuck_a", {shi_a, slo_a}, 0);
        end
        #9 rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    int n;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_period_a", period_a, 0);
        check("reset_high_a", high_a, 0);
        check("reset_valid_a", valid_a, 0);
        check("reset_stuck_a", {shi_a, slo_a}, 0);
        check("reset_period_b", period_b, 0);
        check("reset_stuck_b", {shi_b, slo_b}, 0);
        rst_n = 1'b1;
        tick();

        // Steady 1024/300: first rise silent, then one measurement per period
        do_reset(1'b0);
        wave(1'b0, 1024, 300, 4);
        pulse_rise(1'b0);
        repeat (4) tick();
        check("steady_count", vper_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("steady_period", qget(vper_a, i), 1024);
            check("steady_high", qget(vhi_a, i), 300);
        end
        check("steady_latency_first", qget(vcyc_a, 0), qget(rise_cyc, 1) + 3);
        check("steady_latency_last", qget(vcyc_a, 3), qget(rise_cyc, 4) + 3);
        check("steady_no_stuck", {shi_a, slo_a}, 0);

        // Duty sweep points at period 1024
        do_reset(1'b0);
        wave(1'b0, 1024, 1, 1);
        wave(1'b0, 1024, 512, 1);
        wave(1'b0, 1024, 1023, 1);
        pulse_rise(1'b0);
        repeat (4) tick();
        check("duty_count", vper_a.size(), 3);
        check("duty_high_1", qget(vhi_a, 0), 1);
        check("duty_high_512", qget(vhi_a, 1), 512);
        check("duty_high_1023", qget(vhi_a, 2), 1023);
        check("duty_period_1023", qget(vper_a, 2), 1024);

        // Asynchronous reset mid-period discards state
        do_reset(1'b0);
        wave(1'b0, 1024, 300, 2);
        pulse_rise(1'b0);
        repeat (500) tick();
        check("prereset_period_a", period_a, 1024);
        do_reset(1'b1);
        wave(1'b0, 1024, 300, 1);
        pulse_rise(1'b0);
        repeat (4) tick();
        check("postreset_count", vper_a.size(), 1);
        check("postreset_latency", qget(vcyc_a, 0), qget(rise_cyc, 1) + 3);
        check("postreset_high", qget(vhi_a, 0), 300);

        // 8-bit: line held low after running -> stuck_lo after 255 cycles
        do_reset(1'b0);
        wave(1'b1, 20, 5, 2);
        pulse_rise(1'b1);
        n = qget(rise_cyc, 2);
        while (cyc < n + 257) tick();
        check("stuck_lo_early", slo_b, 0);
        tick();
        check("stuck_lo_set", slo_b, 1);
        check("stuck_lo_not_hi", shi_b, 0);
        check("stuck_lo_hold_period", period_b, 20);
        check("stuck_lo_hold_high", high_b, 5);
        clear_q();
        wave(1'b1, 20, 5, 1);
        check("stuck_lo_cleared", slo_b, 0);
        check("stuck_lo_first_rise_silent", vper_b.size(), 0);
        pulse_rise(1'b1);
        repeat (3) tick();
        check("stuck_lo_resume_count", vper_b.size(), 1);
        check("stuck_lo_resume_period", qget(vper_b, 0), 20);

        // 8-bit: constant high -> stuck_hi
        do_reset(1'b0);
        drive(1'b1, 1'b1);
        n = cyc;
        while (cyc < n + 257) tick();
        check("stuck_hi_early", shi_b, 0);
        tick();
        check("stuck_hi_set", shi_b, 1);
        check("stuck_hi_not_lo", slo_b, 0);
        check("stuck_hi_no_valid", vper_b.size(), 0);

        // 8-bit: minimum period, toggle every cycle
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) pulse_rise(1'b1);
        repeat (5) tick();
        check("minper_count", vper_b.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check("minper_period", qget(vper_b, i), 2);
            check("minper_high", qget(vhi_b, i), 1);
        end

        // 8-bit: rise lands exactly when cnt_period reaches CNT_MAX
        do_reset(1'b0);
        drive(1'b1, 1'b1);
        n = cyc;
        tick();
        drive(1'b1, 1'b0);
        while (cyc < n + 255) tick();
        drive(1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0);
        while (cyc < n + 257) tick();
        check("sat_no_early_stuck", slo_b, 0);
        tick();
        check("sat_valid", valid_b, 1);
        check("sat_period", period_b, 255);
        check("sat_high", high_b, 1);
        check("sat_no_stuck", {shi_b, slo_b}, 0);

        check("valid_width_a", wide_a, 0);
        check("valid_width_b", wide_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
